// File: rtl/serial_parity_checker_if.sv
// Handshake/bus bundle for serial_parity_checker.
//   master : bit source (drives start/abort/bit_valid/bit_in, observes results)
//   slave  : the checker itself
//   start, abort, bit_valid, bit_in : source -> checker
//   busy, done, parity_err, data_out : checker -> downstream
interface serial_parity_checker_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 abort;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 busy;
  logic                 done;
  logic                 parity_err;
  logic [DATA_BITS-1:0] data_out;

  modport master (
    output start, abort, bit_valid, bit_in,
    input  busy, done, parity_err, data_out
  );

  modport slave (
    input  start, abort, bit_valid, bit_in,
    output busy, done, parity_err, data_out
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: collects DATA_BITS data bits (LSB first) plus one
// parity bit through a running XOR, then reports the word, a parity-error
// flag and a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_parity_checker_if.slave
//            start/abort/bit_valid/bit_in in; busy/done/parity_err/data_out out
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_parity_checker_if.slave  bus
);
  localparam int   CNT_W = $clog2(DATA_BITS + 1);
  localparam logic ODD   = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 acc;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 err_q;
  logic                 done_q;
  logic                 beat;
  logic                 last_data;

  // abort outranks a same-cycle bit, so a beat only counts without abort
  assign beat      = bus.bit_valid && !bus.abort;
  assign last_data = (cnt == CNT_W'(DATA_BITS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_nxt = DATA;
      DATA:    if (bus.abort)               state_nxt = IDLE;
               else if (beat && last_data)  state_nxt = PARITY;
      PARITY:  if (bus.abort || beat)       state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= 1'b0;
      shreg  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            acc <= 1'b0;
            cnt <= '0;
          end
        end
        DATA: begin
          if (beat) begin
            acc <= acc ^ bus.bit_in;
            for (int i = 0; i < DATA_BITS; i++)
              if (cnt == CNT_W'(i)) shreg[i] <= bus.bit_in;
            // wrap instead of reaching DATA_BITS; cnt is reloaded on start anyway
            cnt <= last_data ? '0 : cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (beat) begin
            err_q  <= acc ^ bus.bit_in ^ ODD;
            data_q <= shreg;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.parity_err = err_q;
  assign bus.data_out   = data_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_BITS(8)) ev ();
  serial_parity_checker_if #(.DATA_BITS(8)) od ();

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .bus(ev));
  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bus(od));

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q_ev[$];
  exp_t q_od[$];
  exp_t e_ev, e_od;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumers: every done pulse must match the oldest pending frame
  always @(negedge clk) begin
    if (rst_n && ev.done) begin
      if (q_ev.size() == 0) check("even_unexpected_done", 1, 0);
      else begin
        e_ev = q_ev.pop_front();
        check({e_ev.tag, "_data"}, ev.data_out, e_ev.data);
        check({e_ev.tag, "_err"},  ev.parity_err, e_ev.err);
        check({e_ev.tag, "_busy_in_done"}, ev.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && od.done) begin
      if (q_od.size() == 0) check("odd_unexpected_done", 1, 0);
      else begin
        e_od = q_od.pop_front();
        check({e_od.tag, "_data"}, od.data_out, e_od.data);
        check({e_od.tag, "_err"},  od.parity_err, e_od.err);
        check({e_od.tag, "_busy_in_done"}, od.busy, 0);
      end
    end
  end

  task automatic drive(input bit odd, input logic st, input logic ab,
                       input logic bv, input logic bi);
    ev.start = 1'b0; ev.abort = 1'b0; ev.bit_valid = 1'b0; ev.bit_in = 1'b0;
    od.start = 1'b0; od.abort = 1'b0; od.bit_valid = 1'b0; od.bit_in = 1'b0;
    if (odd) begin
      od.start = st; od.abort = ab; od.bit_valid = bv; od.bit_in = bi;
    end else begin
      ev.start = st; ev.abort = ab; ev.bit_valid = bv; ev.bit_in = bi;
    end
  endtask

  // hold one input pattern across the next active edge, return at edge+1
  task automatic cyc(input bit odd, input logic st, input logic ab,
                     input logic bv, input logic bi);
    drive(odd, st, ab, bv, bi);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit odd, input logic [7:0] word, input logic par,
                            input int maxgap, input bit midstart, input string tag);
    exp_t x;
    cyc(odd, 1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, "_busy"}, odd ? od.busy : ev.busy, 1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(maxgap, 0)) cyc(odd, 1'b0, 1'b0, 1'b0, 1'b0);
      if (midstart && i == 3) cyc(odd, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(odd, 1'b0, 1'b0, 1'b1, word[i]);
    end
    x.tag  = tag;
    x.data = word;
    x.err  = (^word) ^ par ^ odd;
    if (odd) q_od.push_back(x); else q_ev.push_back(x);
    cyc(odd, 1'b0, 1'b0, 1'b1, par);
    drive(odd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q_ev.size() + q_od.size()) != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, q_ev.size() + q_od.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  {ev.busy, od.busy}, 0);
    check("rst_done",  {ev.done, od.done}, 0);
    check("rst_err",   {ev.parity_err, od.parity_err}, 0);
    check("rst_data",  {ev.data_out, od.data_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // start+abort in IDLE: abort wins
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_start_abort_busy", ev.busy, 0);

    send_frame(1'b0, 8'hA5, 1'b0, 0, 1'b0, "even_a5_p0");
    wait_drain("t1");
    send_frame(1'b0, 8'hA5, 1'b1, 0, 1'b0, "even_a5_p1");
    wait_drain("t2");
    send_frame(1'b1, 8'h01, 1'b0, 0, 1'b0, "odd_01_p0");
    wait_drain("t3a");
    send_frame(1'b1, 8'h01, 1'b1, 0, 1'b0, "odd_01_p1");
    wait_drain("t3b");
    send_frame(1'b0, 8'h3C, 1'b0, 5, 1'b1, "even_3c_gaps");
    wait_drain("t4");

    // abort after 4 bits, abort colliding with a valid bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("abort_busy", ev.busy, 0);
    check("abort_keep_data", ev.data_out, 8'h3C);
    check("abort_keep_err", ev.parity_err, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'hFF, 1'b0, 1, 1'b0, "even_ff_p0");
    wait_drain("t5");

    // reset in the middle of a frame
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", ev.busy, 0);
    check("midrst_data", ev.data_out, 0);
    check("midrst_err",  ev.parity_err, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back: second start lands in the first frame's done cycle
    send_frame(1'b0, 8'h0F, 1'b0, 0, 1'b0, "b2b_0f");
    send_frame(1'b0, 8'h0E, 1'b0, 0, 1'b0, "b2b_0e");
    wait_drain("t6");
    check("final_busy", ev.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
